// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: position/velocity store for N_OBJ sprite slots.
// One ballistic step per frame (x+=vx, y+=vy, vy+=gravity clamped to VMAX),
// swept one slot per clock after each frame_tick. Objects enter through a
// valid/ready spawn port and leave by kill, by falling off the bottom edge,
// or by leaving the screen sideways.
module sprite_motion_ctrl #(
  parameter int N_OBJ    = 4,
  parameter int VEL_W    = 8,
  parameter int GRAVITY  = 1,
  parameter int VMAX     = 12,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  localparam int IDX_W   = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic                   spawn_valid,
  output logic                   spawn_ready,
  input  logic [9:0]             spawn_x,
  input  logic [8:0]             spawn_y,
  input  logic [VEL_W-1:0]       spawn_vx,
  input  logic [VEL_W-1:0]       spawn_vy,
  input  logic                   kill_valid,
  input  logic [IDX_W-1:0]       kill_idx,
  output logic [N_OBJ-1:0]       active,
  output logic [N_OBJ*10-1:0]    pos_x,
  output logic [N_OBJ*9-1:0]     pos_y,
  output logic                   busy,
  output logic                   lost_pulse,
  output logic [IDX_W-1:0]       lost_idx,
  output logic                   overrun
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_UPDATE = 1'b1;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_OBJ - 1);
  localparam logic signed [11:0] SW_S    = 12'(SCREEN_W);
  localparam logic signed [11:0] SH_S    = 12'(SCREEN_H);
  localparam logic signed [11:0] VMAX_S  = 12'(VMAX);
  localparam logic signed [11:0] GRAV_S  = 12'(GRAVITY);

  logic [0:0]              state;
  logic [IDX_W-1:0]        idx;
  logic                    skip_first;   // slot 0 was spawned on the tick edge
  logic [9:0]              xs  [N_OBJ];
  logic [8:0]              ys  [N_OBJ];
  logic signed [VEL_W-1:0] vxs [N_OBJ];
  logic signed [VEL_W-1:0] vys [N_OBJ];

  logic [IDX_W-1:0]  free_idx;
  logic              free_found;
  logic              spawn_acc;
  logic              kill_ok;
  logic              kill_cur;
  logic signed [11:0] cur_vx, cur_vy, xn, yn, vyn, vy_sat;
  logic [8:0]        y_clamped;
  logic              upd_en, is_lost, is_out, do_move;
  logic [N_OBJ-1:0]  active_nx;

  assign spawn_ready = (state == S_IDLE) && !(&active) && !rst;
  assign spawn_acc   = spawn_valid && spawn_ready;
  assign kill_ok     = kill_valid && (int'(kill_idx) < N_OBJ);
  assign kill_cur    = kill_ok && (kill_idx == idx);

  // Lowest-index free slot for the next spawn.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (!active[i] && !free_found) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end else begin
        free_found = free_found;
      end
    end
  end

  // Ballistic step and bounds classification for the slot under sweep.
  always_comb begin
    cur_vx  = 12'(vxs[idx]);
    cur_vy  = 12'(vys[idx]);
    xn      = $signed({2'b00, xs[idx]}) + cur_vx;
    yn      = $signed({3'b000, ys[idx]}) + cur_vy;
    vyn     = cur_vy + GRAV_S;
    if (vyn > VMAX_S) begin
      vy_sat = VMAX_S;
    end else begin
      vy_sat = vyn;
    end
    if (yn < 12'sd0) begin
      y_clamped = 9'd0;
    end else begin
      y_clamped = yn[8:0];
    end
    // Kill on the swept slot wins over any motion outcome.
    upd_en  = (state == S_UPDATE) && active[idx] && !kill_cur &&
              !(skip_first && (idx == '0));
    is_lost = upd_en && (yn >= SH_S) && (cur_vy > 12'sd0);
    is_out  = upd_en && !is_lost && ((xn < 12'sd0) || (xn >= SW_S));
    do_move = upd_en && !is_lost && !is_out;
  end

  // Next occupancy: kill and sweep removals first, spawn set last.
  always_comb begin
    active_nx = active;
    if (kill_ok) begin
      active_nx[kill_idx] = 1'b0;
    end else begin
      active_nx = active_nx;
    end
    if (is_lost || is_out) begin
      active_nx[idx] = 1'b0;
    end else begin
      active_nx = active_nx;
    end
    if (spawn_acc) begin
      active_nx[free_idx] = 1'b1;
    end else begin
      active_nx = active_nx;
    end
  end

  // Pack slot positions onto the renderer buses.
  always_comb begin
    pos_x = '0;
    pos_y = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      pos_x[i*10 +: 10] = xs[i];
      pos_y[i*9 +: 9]   = ys[i];
    end
  end

  // Sweep FSM, status pulses and slot storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      skip_first <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      lost_pulse <= 1'b0;
      lost_idx   <= '0;
      active     <= '0;
      for (int i = 0; i < N_OBJ; i++) begin
        xs[i]  <= 10'd0;
        ys[i]  <= 9'd0;
        vxs[i] <= '0;
        vys[i] <= '0;
      end
    end else begin
      overrun    <= frame_tick && (state == S_UPDATE);
      lost_pulse <= is_lost;
      if (is_lost) begin
        lost_idx <= idx;
      end
      active <= active_nx;
      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            state      <= S_UPDATE;
            busy       <= 1'b1;
            idx        <= '0;
            skip_first <= spawn_acc && (free_idx == '0);
          end
        end
        S_UPDATE: begin
          if (idx == LAST_IDX) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          idx   <= '0;
        end
      endcase
      if (spawn_acc) begin
        xs[free_idx]  <= spawn_x;
        ys[free_idx]  <= spawn_y;
        vxs[free_idx] <= spawn_vx;
        vys[free_idx] <= spawn_vy;
      end
      if (do_move) begin
        xs[idx]  <= xn[9:0];
        ys[idx]  <= y_clamped;
        vys[idx] <= VEL_W'(vy_sat);
      end
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl (default parameters, 4 slots).
// Stimulus pushes hand-computed expectations; a negedge monitor pops them
// when a sweep ends, a lost pulse appears, or overrun pulses.
module tb_sprite_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        spawn_valid = 1'b0;
  logic        spawn_ready;
  logic [9:0]  spawn_x = 10'd0;
  logic [8:0]  spawn_y = 9'd0;
  logic [7:0]  spawn_vx = 8'd0;
  logic [7:0]  spawn_vy = 8'd0;
  logic        kill_valid = 1'b0;
  logic [1:0]  kill_idx = 2'd0;
  logic [3:0]  active;
  logic [39:0] pos_x;
  logic [35:0] pos_y;
  logic        busy;
  logic        lost_pulse;
  logic [1:0]  lost_idx;
  logic        overrun;

  sprite_motion_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_vx(spawn_vx), .spawn_vy(spawn_vy),
    .kill_valid(kill_valid), .kill_idx(kill_idx),
    .active(active), .pos_x(pos_x), .pos_y(pos_y), .busy(busy),
    .lost_pulse(lost_pulse), .lost_idx(lost_idx), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  act;
    logic [3:0]  mask;
    logic [39:0] px;
    logic [35:0] py;
    logic [7:0]  len;
  } frame_t;

  frame_t frame_q[$];
  int     lost_q[$];
  int     ov_q[$];
  int     total = 0;
  int     bad = 0;
  logic [9:0] ex [4];
  logic [8:0] ey [4];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push_frame(input logic [3:0] act, input logic [3:0] mask, input int len);
    frame_t f;
    f.act  = act;
    f.mask = mask;
    f.len  = 8'(len);
    f.px   = '0;
    f.py   = '0;
    for (int i = 0; i < 4; i++) begin
      f.px[i*10 +: 10] = ex[i];
      f.py[i*9 +: 9]   = ey[i];
    end
    frame_q.push_back(f);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spawn(input logic [9:0] x, input logic [8:0] y, input logic [7:0] vx, input logic [7:0] vy);
    spawn_x = x; spawn_y = y; spawn_vx = vx; spawn_vy = vy;
    chk("spawn_ready", spawn_ready, 1);
    spawn_valid = 1'b1;
    step();
    spawn_valid = 1'b0;
  endtask

  task automatic kill(input int i);
    kill_idx = 2'(i);
    kill_valid = 1'b1;
    step();
    kill_valid = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 20 && busy; c++) step();
    chk("sweep_done", busy, 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  int blen = 0;
  frame_t mf;
  int me;
  always @(negedge clk) begin
    if (busy) begin
      blen++;
    end else if (blen > 0) begin
      chk("frame_expected", frame_q.size() > 0, 1);
      if (frame_q.size() > 0) begin
        mf = frame_q.pop_front();
        chk("busy_len", blen, mf.len);
        chk("active", active, mf.act);
        for (int i = 0; i < 4; i++) begin
          if (mf.mask[i]) begin
            chk($sformatf("pos_x%0d", i), pos_x[i*10 +: 10], mf.px[i*10 +: 10]);
            chk($sformatf("pos_y%0d", i), pos_y[i*9 +: 9], mf.py[i*9 +: 9]);
          end
        end
      end
      blen = 0;
    end
    if (lost_pulse) begin
      chk("lost_expected", lost_q.size() > 0, 1);
      if (lost_q.size() > 0) begin
        me = lost_q.pop_front();
        chk("lost_idx", lost_idx, me);
        chk("lost_time", blen, me + 2);
      end
    end
    if (overrun) begin
      chk("overrun_expected", ov_q.size() > 0, 1);
      if (ov_q.size() > 0) me = ov_q.pop_front();
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin ex[i] = 10'd0; ey[i] = 9'd0; end
    repeat (3) step();
    chk("rst_ready", spawn_ready, 0);
    chk("rst_active", active, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pos_x", pos_x, 0);
    chk("rst_pos_y", pos_y, 0);
    chk("rst_lost", {lost_pulse, lost_idx}, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", spawn_ready, 1);

    // Basic flight: two frames of slot 0.
    spawn(10'd100, 9'd400, 8'd3, -8'sd10);
    ex[0] = 10'd103; ey[0] = 9'd390;
    push_frame(4'b0001, 4'b0001, 4);
    tick();
    chk("ready_in_sweep", spawn_ready, 0);
    wait_idle();
    ex[0] = 10'd106; ey[0] = 9'd381;
    push_frame(4'b0001, 4'b0001, 4);
    tick();
    wait_idle();
    kill(0);
    chk("kill0", active, 0);

    // Fall off the bottom.
    lost_q.push_back(0);
    push_frame(4'b0000, 4'b0000, 4);
    spawn(10'd200, 9'd470, 8'd0, 8'd12);
    tick();
    wait_idle();
    spawn(10'd50, 9'd100, 8'd1, 8'd1);
    chk("slot0_reused", active, 4'b0001);

    // Fill, kill slot 2, refill slot 2, then one multi-slot frame.
    spawn(10'd10, 9'd10, 8'd0, 8'd0);
    spawn(10'd20, 9'd20, 8'd0, 8'd0);
    spawn(10'd30, 9'd30, 8'd0, 8'd0);
    chk("full_active", active, 4'b1111);
    chk("full_ready", spawn_ready, 0);
    kill(2);
    chk("after_kill_ready", spawn_ready, 1);
    spawn(10'd40, 9'd40, 8'd0, 8'd0);
    chk("refill_active", active, 4'b1111);
    chk("refill_slot2_x", pos_x[29:20], 10'd40);
    ex[0] = 10'd51; ey[0] = 9'd101;
    ex[1] = 10'd10; ey[1] = 9'd10;
    ex[2] = 10'd40; ey[2] = 9'd40;
    ex[3] = 10'd30; ey[3] = 9'd30;
    push_frame(4'b1111, 4'b1111, 4);
    tick();
    wait_idle();
    for (int i = 0; i < 4; i++) kill(i);
    chk("all_killed", active, 0);

    // Spawn on the tick edge into slot 0: not moved this frame.
    ex[0] = 10'd100; ey[0] = 9'd100;
    push_frame(4'b0001, 4'b0001, 4);
    spawn_x = 10'd100; spawn_y = 9'd100; spawn_vx = 8'd0; spawn_vy = 8'd5;
    chk("spawn_ready", spawn_ready, 1);
    spawn_valid = 1'b1;
    tick();
    spawn_valid = 1'b0;
    wait_idle();
    kill(0);

    // Sideways exit: silent deactivate.
    push_frame(4'b0000, 4'b0000, 4);
    spawn(10'd620, 9'd200, 8'd25, 8'd0);
    tick();
    wait_idle();
    // Top clamp.
    ex[0] = 10'd300; ey[0] = 9'd0;
    push_frame(4'b0001, 4'b0001, 4);
    spawn(10'd300, 9'd5, 8'd0, -8'sd20);
    tick();
    wait_idle();
    kill(0);

    // Tick while busy: overrun, sweep unchanged.
    spawn(10'd100, 9'd100, 8'd2, 8'd0);
    ex[0] = 10'd102; ey[0] = 9'd100;
    push_frame(4'b0001, 4'b0001, 4);
    ov_q.push_back(1);
    tick();
    step();
    tick();
    wait_idle();
    ex[0] = 10'd104; ey[0] = 9'd101;
    push_frame(4'b0001, 4'b0001, 4);
    tick();
    wait_idle();
    kill(0);

    // Reset in the second cycle of a sweep.
    spawn(10'd100, 9'd200, 8'd1, 8'd1);
    for (int i = 0; i < 4; i++) begin ex[i] = 10'd0; ey[i] = 9'd0; end
    push_frame(4'b0000, 4'b1111, 2);
    tick();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_ready", spawn_ready, 1);
    chk("midrst_busy", busy, 0);
    spawn(10'd10, 9'd20, 8'd1, 8'd1);
    ex[0] = 10'd11; ey[0] = 9'd21;
    push_frame(4'b0001, 4'b0001, 4);
    tick();
    wait_idle();

    repeat (3) step();
    chk("frame_q_empty", frame_q.size(), 0);
    chk("lost_q_empty", lost_q.size(), 0);
    chk("ov_q_empty", ov_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Parametrised motion engine for the fruit/blade sprites. It holds position and velocity for `N_OBJ` object slots and performs one ballistic step per frame on every active slot: add velocity, then apply gravity. New objects are spawned through a valid/ready handshake. It sits between game logic and the `displayObj` renderers, driving their `posx`/`posy` inputs in place of the fixed per-object registers used today.

## Interface
Parameters:
- `N_OBJ`, 4: number of object slots (1–16).
- `VEL_W`, 8: signed velocity width, in pixels per frame.
- `GRAVITY`, 1: added to `vy` each frame (unsigned, < 2^(VEL_W-1)).
- `VMAX`, 12: positive saturation limit for `vy`.
- `SCREEN_W`, 640; `SCREEN_H`, 480: visible area.

Ports:
- `clk` in 1: system clock, same domain as the `displayObj` clock.
- `rst` in 1: synchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse, once per frame (start of vertical blank).
- `spawn_valid` in 1; `spawn_ready` out 1: spawn handshake.
- `spawn_x` in 10, `spawn_y` in 9: start position (unsigned).
- `spawn_vx` in VEL_W, `spawn_vy` in VEL_W: start velocity (signed; negative `vy` means upward).
- `kill_valid` in 1; `kill_idx` in clog2(N_OBJ): deactivate a slot (fruit sliced).
- `active` out N_OBJ: slot-occupied flags.
- `pos_x` out N_OBJ*10; `pos_y` out N_OBJ*9: packed positions; slot i occupies bits [i*10 +: 10] and [i*9 +: 9].
- `busy` out 1: update sweep in progress.
- `lost_pulse` out 1; `lost_idx` out clog2(N_OBJ): an object fell off the bottom edge.
- `overrun` out 1: pulses when `frame_tick` arrives while `busy`.

## Operation
- FSM states:
  - IDLE: on `frame_tick`, go to UPDATE with idx=0.
  - UPDATE: process slot idx on each edge; after slot N_OBJ-1, return to IDLE.
- Update of an active slot, computed in 12-bit signed arithmetic:
  - xn = x + vx; yn = y + vy.
  - vy' = min(vy + GRAVITY, VMAX).
  - vx is unchanged.
- Bounds:
  - yn ≥ SCREEN_H with vy > 0: clear the slot's `active` bit and pulse `lost_pulse` with `lost_idx`=idx.
  - xn < 0 or xn ≥ SCREEN_W: clear `active` silently, no lost pulse.
  - yn < 0: clamp y to 0; vy' is applied as normal.
- Inactive slots are skipped; their state is left untouched, but the sweep still spends one cycle on them.
- Spawning:
  - `spawn_ready` = (state==IDLE) && (~&active) && !rst.
  - On accept, the lowest-index free slot is loaded and its `active` bit is set at the next edge.
- Kill:
  - Accepted in any state; clears `active[kill_idx]` at the next edge.
  - Kill on an inactive slot is a no-op.
  - If the kill targets the slot being updated that cycle, the kill wins: no lost pulse, and the slot ends inactive.
- Simultaneous events:
  - Spawn and kill in the same cycle both take effect.
  - A spawned slot is always free, so a kill aimed at it is a no-op.
  - `frame_tick` together with an accepted spawn: the spawn is loaded, and the sweep that starts on the same edge sees the slot from the next cycle onward. The new slot therefore moves in this frame only if its index is > 0.
- `frame_tick` while `busy`: ignored, and `overrun` pulses for one cycle.

## Timing
- Reset values: `active`=0, all positions and velocities 0, `busy`=0, `lost_pulse`=0, `lost_idx`=0, `overrun`=0, state IDLE. `spawn_ready` is 0 while `rst` is high and 1 in the first cycle after release.
- `frame_tick` sampled at edge t:
  - `busy`=1 from t through t+N_OBJ-1 edges, i.e. for exactly N_OBJ cycles.
  - Slot i is written at edge t+1+i.
- `pos_x`, `pos_y`, `active`, `lost_pulse` and `lost_idx` are registered. Each changes at the write edge of its slot, and `lost_pulse` lasts one cycle.
- A reset asserted mid-sweep aborts the sweep and restores all reset values at the next edge.

## Test plan
- Reset, then spawn (100,400,vx=3,vy=-10), then one `frame_tick` → slot0 at (103,390), vy=-9, `busy` high for 4 cycles, `spawn_ready` low during them.
- Spawn at y=470, vy=+12, then tick → `lost_pulse` with `lost_idx`=0 at edge t+1; `active[0]` clears; slot reusable by the next spawn.
- Fill all 4 slots → `spawn_ready`=0. Kill slot 2 → the next spawn lands in slot 2.
- Spawn (620,200,vx=+25,vy=0), then tick → slot deactivated, no `lost_pulse`. Separately, vy=-20 at y=5 → y clamps to 0, vy=-19.
- Tick while `busy` → `overrun` pulses once; the sweep completes unchanged.
- Assert `rst` at cycle 2 of a sweep → all outputs return to reset values, and the next tick starts a fresh sweep.
